// File: rtl/sfp_frame_capture.sv
// sfp_frame_capture
// Captures one Avalon-ST frame (32-bit beats, first symbol in [31:24]) into a
// zero-wait-state on-chip RAM after an arm pulse. Beats before the SOP are
// discarded. Frames longer than the memory are truncated and flagged with
// overflow. The write pointer never wraps.
// Optional feature: define CAPTURE_BYTECOUNT_EN to add the frame_bytes output
// (byte count of the captured frame, valid with done).
module sfp_frame_capture #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              arm,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   frame_len,
`ifdef CAPTURE_BYTECOUNT_EN
    output logic [ADDR_W+2:0] frame_bytes,
`endif
    input  logic [31:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic [1:0]        in_empty,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic [3:0]        mem_byteenable,
    output logic              mem_clken
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOP = 2'd1,
        ST_CAPTURE  = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    // Memory depth expressed as a word count (one bit wider than the address).
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    // Byte lanes written on the EOP beat: invalid bytes are the low lanes.
    function automatic logic [3:0] eop_byteenable(input logic [1:0] empty);
        logic [3:0] be;
        case (empty)
            2'd0:    be = 4'b1111;
            2'd1:    be = 4'b1110;
            2'd2:    be = 4'b1100;
            2'd3:    be = 4'b1000;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    logic [1:0]        rst_sync_r;
    logic              run_s;
    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W:0]   ptr_r;
    logic [ADDR_W:0]   ptr_s;
    logic [ADDR_W:0]   next_ptr_s;
    logic              accept_s;
    logic              write_s;
    logic              clear_s;
    logic              finish_s;
    logic              trunc_s;
    logic              busy_r;
    logic              in_ready_r;
    logic              done_r;
    logic              done_s;
    logic              overflow_r;
    logic              overflow_s;
    logic [ADDR_W:0]   frame_len_r;
    logic [ADDR_W:0]   frame_len_s;
    logic              mem_write_r;
    logic [ADDR_W-1:0] mem_address_r;
    logic [31:0]       mem_writedata_r;
    logic [3:0]        mem_byteenable_r;

    assign run_s = rst_sync_r[1];

    // Reset release synchronizer: assertion is immediate, release takes two clocks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    // Next-state and status decisions for the capture FSM.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        done_s      = done_r;
        overflow_s  = overflow_r;
        frame_len_s = frame_len_r;
        write_s     = 1'b0;
        clear_s     = 1'b0;
        finish_s    = 1'b0;
        trunc_s     = 1'b0;
        next_ptr_s  = ptr_r + {{ADDR_W{1'b0}}, 1'b1};
        accept_s    = in_valid & in_ready_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_s     = ST_WAIT_SOP;
                    clear_s     = 1'b1;
                    done_s      = 1'b0;
                    overflow_s  = 1'b0;
                    frame_len_s = {(ADDR_W+1){1'b0}};
                    ptr_s       = {(ADDR_W+1){1'b0}};
                end else begin
                    state_s = state_r;
                end
            end
            ST_WAIT_SOP: begin
                if (accept_s && in_sop) begin
                    write_s = 1'b1;
                    ptr_s   = next_ptr_s;
                    if (in_eop) begin
                        state_s     = ST_DONE;
                        done_s      = 1'b1;
                        frame_len_s = next_ptr_s;
                        finish_s    = 1'b1;
                    end else begin
                        state_s = ST_CAPTURE;
                    end
                end else begin
                    state_s = ST_WAIT_SOP;
                end
            end
            ST_CAPTURE: begin
                if (accept_s) begin
                    if (!overflow_r) begin
                        write_s = 1'b1;
                        ptr_s   = next_ptr_s;
                        if (in_eop) begin
                            state_s     = ST_DONE;
                            done_s      = 1'b1;
                            frame_len_s = next_ptr_s;
                            finish_s    = 1'b1;
                        end else if (next_ptr_s == DEPTH) begin
                            // Memory is full and the frame continues: stop writing.
                            overflow_s = 1'b1;
                        end else begin
                            overflow_s = 1'b0;
                        end
                    end else if (in_eop) begin
                        state_s     = ST_DONE;
                        done_s      = 1'b1;
                        frame_len_s = ptr_r;
                        trunc_s     = 1'b1;
                    end else begin
                        state_s = ST_CAPTURE;
                    end
                end else begin
                    state_s = ST_CAPTURE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, write pointer and registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            ptr_r       <= {(ADDR_W+1){1'b0}};
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b0;
            done_r      <= 1'b0;
            overflow_r  <= 1'b0;
            frame_len_r <= {(ADDR_W+1){1'b0}};
        end else if (!run_s) begin
            state_r     <= ST_IDLE;
            ptr_r       <= {(ADDR_W+1){1'b0}};
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b0;
            done_r      <= 1'b0;
            overflow_r  <= 1'b0;
            frame_len_r <= {(ADDR_W+1){1'b0}};
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            busy_r      <= (state_s == ST_WAIT_SOP) || (state_s == ST_CAPTURE);
            in_ready_r  <= (state_s == ST_WAIT_SOP) || (state_s == ST_CAPTURE);
            done_r      <= done_s;
            overflow_r  <= overflow_s;
            frame_len_r <= frame_len_s;
        end
    end

    // Memory write port: one-cycle write strobe the cycle after a beat is taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_write_r      <= 1'b0;
            mem_address_r    <= {ADDR_W{1'b0}};
            mem_writedata_r  <= 32'h0000_0000;
            mem_byteenable_r <= 4'b1111;
        end else if (write_s && run_s) begin
            mem_write_r      <= 1'b1;
            mem_address_r    <= ptr_r[ADDR_W-1:0];
            mem_writedata_r  <= in_data;
            mem_byteenable_r <= in_eop ? eop_byteenable(in_empty) : 4'b1111;
        end else begin
            mem_write_r      <= 1'b0;
            mem_byteenable_r <= 4'b1111;
        end
    end

`ifdef CAPTURE_BYTECOUNT_EN
    logic [ADDR_W+2:0] frame_bytes_r;

    // Byte count of the last frame; a truncated frame counts every stored byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_bytes_r <= {(ADDR_W+3){1'b0}};
        end else if (!run_s || clear_s) begin
            frame_bytes_r <= {(ADDR_W+3){1'b0}};
        end else if (finish_s) begin
            frame_bytes_r <= {next_ptr_s, 2'b00} - {{(ADDR_W+1){1'b0}}, in_empty};
        end else if (trunc_s) begin
            frame_bytes_r <= {ptr_r, 2'b00};
        end else begin
            frame_bytes_r <= frame_bytes_r;
        end
    end

    assign frame_bytes = frame_bytes_r;
`endif

    assign busy           = busy_r;
    assign in_ready       = in_ready_r;
    assign done           = done_r;
    assign overflow       = overflow_r;
    assign frame_len      = frame_len_r;
    assign mem_write      = mem_write_r;
    assign mem_chipselect = mem_write_r;
    assign mem_address    = mem_address_r;
    assign mem_writedata  = mem_writedata_r;
    assign mem_byteenable = mem_byteenable_r;
    assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_sfp_frame_capture.sv
// Bench for sfp_frame_capture (ADDR_W=4): directed scenarios plus random
// frames, checked every cycle against a frame-level behavioural model.
module tb_sfp_frame_capture;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              arm = 1'b0;
    logic              busy, done, overflow;
    logic [ADDR_W:0]   frame_len;
`ifdef CAPTURE_BYTECOUNT_EN
    logic [ADDR_W+2:0] frame_bytes;
`endif
    logic [31:0]       in_data = 32'h0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_sop = 1'b0;
    logic              in_eop = 1'b0;
    logic [1:0]        in_empty = 2'd0;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect, mem_write, mem_clken;
    logic [31:0]       mem_writedata;
    logic [3:0]        mem_byteenable;

    sfp_frame_capture #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .arm(arm), .busy(busy), .done(done),
        .overflow(overflow), .frame_len(frame_len),
`ifdef CAPTURE_BYTECOUNT_EN
        .frame_bytes(frame_bytes),
`endif
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_writedata(mem_writedata),
        .mem_byteenable(mem_byteenable), .mem_clken(mem_clken)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: phase 0 idle, 1 waiting for SOP, 2 capturing, 3 finished.
    int          m_phase = 0;
    int          m_cnt = 0;
    int          m_len = 0;
    int          m_bytes = 0;
    int          m_edges = 0;
    logic        m_done = 1'b0;
    logic        m_ovf = 1'b0;
    logic        m_wr = 1'b0;
    logic [3:0]  m_be = 4'hF;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] m_data = 32'h0;

    logic [31:0] dut_mem [DEPTH];
    logic [31:0] sent_w  [DEPTH];
    int          dut_wr_cnt = 0;
    logic [3:0]  last_be = 4'h0;
    int          last_addr = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_len = 0; m_bytes = 0; m_edges = 0;
        m_done = 1'b0; m_ovf = 1'b0; m_wr = 1'b0; m_be = 4'hF;
        m_addr = 32'h0; m_data = 32'h0;
    endtask

    task automatic take_beat();
        logic [3:0] full;
        full = 4'hF;
        if (m_cnt < DEPTH) begin
            m_wr = 1'b1;
            m_addr = m_cnt;
            m_data = in_data;
            m_be = in_eop ? (full << in_empty) : 4'hF;
            m_cnt++;
            if (!in_eop && m_cnt == DEPTH) m_ovf = 1'b1;
        end
        if (in_eop) begin
            m_phase = 3;
            m_done = 1'b1;
            m_len = m_cnt;
            m_bytes = m_ovf ? 4 * m_cnt : 4 * m_cnt - int'(in_empty);
        end else if (m_phase == 1) begin
            m_phase = 2;
        end
    endtask

    // Advances the model across one rising edge using the current inputs.
    task automatic model_edge();
        logic acc;
        if (reset_n !== 1'b1) return;
        if (m_edges < 2) begin
            m_edges++;
            return;
        end
        acc = in_valid && (m_phase == 1 || m_phase == 2);
        m_wr = 1'b0;
        m_be = 4'hF;
        case (m_phase)
            0, 3: if (arm) begin
                m_phase = 1; m_done = 1'b0; m_ovf = 1'b0;
                m_len = 0; m_bytes = 0; m_cnt = 0;
            end
            1: if (acc && in_sop) take_beat();
            2: if (acc) take_beat();
            default: ;
        endcase
    endtask

    task automatic check_outputs();
        logic act_phase;
        act_phase = (m_phase == 1 || m_phase == 2);
        chk("in_ready", 32'(in_ready), 32'(act_phase));
        chk("busy", 32'(busy), 32'(act_phase));
        chk("done", 32'(done), 32'(m_done));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("frame_len", 32'(frame_len), 32'(m_len));
        chk("mem_write", 32'(mem_write), 32'(m_wr));
        chk("mem_chipselect", 32'(mem_chipselect), 32'(m_wr));
        chk("mem_clken", 32'(mem_clken), 32'h1);
        chk("mem_byteenable", 32'(mem_byteenable), 32'(m_be));
        chk("mem_address", 32'(mem_address), m_addr);
        chk("mem_writedata", mem_writedata, m_data);
`ifdef CAPTURE_BYTECOUNT_EN
        chk("frame_bytes", 32'(frame_bytes), 32'(m_bytes));
`endif
        if (mem_write === 1'b1) begin
            dut_mem[mem_address] = mem_writedata;
            dut_wr_cnt++;
            last_be = mem_byteenable;
            last_addr = int'(mem_address);
        end
    endtask

    // One clock: check outputs, apply inputs, advance model, move to next negedge.
    task automatic step(input logic a, input logic v, input logic s, input logic e,
                        input logic [1:0] emp, input logic [31:0] d);
        check_outputs();
        arm = a; in_valid = v; in_sop = s; in_eop = e; in_empty = emp; in_data = d;
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, $urandom);
    endtask

    // Arm, optional junk beats, then an n-beat frame with random valid gaps.
    task automatic send_frame(input int n, input logic [1:0] emp, input int junk, input bit rnd_arm);
        int sent;
        int exp_len;
        logic [31:0] w;
        logic a;
        dut_wr_cnt = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, $urandom);
        for (int j = 0; j < junk; j++)
            step(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 2'($urandom), $urandom);
        sent = 0;
        while (sent < n) begin
            a = rnd_arm && ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) begin
                step(a, 1'b0, 1'b0, 1'b0, 2'd0, $urandom);
            end else begin
                w = $urandom;
                if (sent < DEPTH) sent_w[sent] = w;
                step(a, 1'b1, (sent == 0) ? 1'b1 : ($urandom_range(0, 7) == 0),
                     sent == n - 1, (sent == n - 1) ? emp : 2'($urandom), w);
                sent++;
            end
        end
        idle(2);
        exp_len = (n > DEPTH) ? DEPTH : n;
        chk("rule_done", 32'(done), 32'h1);
        chk("rule_frame_len", 32'(frame_len), 32'(exp_len));
        chk("rule_overflow", 32'(overflow), 32'(n > DEPTH));
        chk("rule_write_count", 32'(dut_wr_cnt), 32'(exp_len));
        chk("rule_last_addr", 32'(last_addr), 32'(exp_len - 1));
`ifdef CAPTURE_BYTECOUNT_EN
        chk("rule_frame_bytes", 32'(frame_bytes),
            32'((n > DEPTH) ? 4 * DEPTH : 4 * n - int'(emp)));
`endif
        for (int i = 0; i < exp_len; i++) chk("rule_mem_word", dut_mem[i], sent_w[i]);
    endtask

    task automatic check_reset_values();
        chk("rst_mem_write", 32'(mem_write), 32'h0);
        chk("rst_chipselect", 32'(mem_chipselect), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        chk("rst_frame_len", 32'(frame_len), 32'h0);
        chk("rst_byteenable", 32'(mem_byteenable), 32'hF);
        chk("rst_address", 32'(mem_address), 32'h0);
        chk("rst_writedata", mem_writedata, 32'h0);
    endtask

    initial begin
        int wr_before;
        model_reset();
        @(negedge clk);
        check_reset_values();
        reset_n = 1'b1;
        idle(3);

        // 5-beat frame, empty=2 on the EOP beat.
        send_frame(5, 2'd2, 0, 1'b0);
        chk("s1_frame_len", 32'(frame_len), 32'd5);
        chk("s1_last_be", 32'(last_be), 32'b1100);
        chk("s1_last_addr", 32'(last_addr), 32'd4);
`ifdef CAPTURE_BYTECOUNT_EN
        chk("s1_frame_bytes", 32'(frame_bytes), 32'd18);
`endif

        // Three discarded non-SOP beats, then a single SOP+EOP beat.
        send_frame(1, 2'd0, 3, 1'b0);
        chk("s2_frame_len", 32'(frame_len), 32'd1);
        chk("s2_writes", 32'(dut_wr_cnt), 32'd1);
        chk("s2_last_addr", 32'(last_addr), 32'd0);

        // 20-beat frame into a 16-word memory.
        send_frame(20, 2'd1, 0, 1'b0);
        chk("s3_overflow", 32'(overflow), 32'd1);
        chk("s3_frame_len", 32'(frame_len), 32'd16);
        chk("s3_writes", 32'(dut_wr_cnt), 32'd16);
        chk("s3_last_addr", 32'(last_addr), 32'd15);

        // EOP exactly on the 16th word.
        send_frame(16, 2'd3, 0, 1'b0);
        chk("s4_overflow", 32'(overflow), 32'd0);
        chk("s4_frame_len", 32'(frame_len), 32'd16);
        chk("s4_last_be", 32'(last_be), 32'b1000);

        // Arm mid-capture is ignored; reset mid-frame aborts with no writes.
        dut_wr_cnt = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'hA0A0_0001);
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'hA0A0_0002);
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'hA0A0_0003);
        chk("s5_busy_after_arm", 32'(busy), 32'h1);
        chk("s5_done_after_arm", 32'(done), 32'h0);
        chk("s5_addr_after_arm", 32'(mem_address), 32'd2);
        in_valid = 1'b1;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_reset_values();
        @(negedge clk);
        wr_before = dut_wr_cnt;
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, $urandom);
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, $urandom);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, $urandom);
        chk("s5_no_writes_after_reset", 32'(dut_wr_cnt), 32'(wr_before));
        chk("s5_idle_after_reset", 32'(busy), 32'h0);

        // Random frames with gaps, stray SOPs and ignored arm pulses.
        for (int k = 0; k < 25; k++) begin
            idle($urandom_range(0, 2));
            send_frame($urandom_range(1, 22), 2'($urandom), $urandom_range(0, 3), 1'b1);
        end

        check_outputs();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
